// File: rtl/step_sequencer_if.sv
// Bundle of request and command signals between a step_sequencer and whatever drives it.
// Carries the sequencer's FSM state outward so checkers can observe it.
interface step_sequencer_if #(
  parameter int WIDTH = 8
);
  // Handshake: start and pl_req are one-cycle requests (valid). The sequencer is ready only
  // while fsm_state is IDLE (2'd0). A request presented at any other time is dropped, not held.
  // pl_req wins over start. abort is honoured only in STEP or GAPW. done pulses one cycle.
  logic [WIDTH-1:0]   target;
  logic               start;
  logic               abort;
  logic               pl_req;
  logic [WIDTH-1:0]   load;
  logic               up;
  logic               down;
  logic               plN_out;
  logic [WIDTH-1:0]   pos;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] LED;
  logic [1:0]         fsm_state;

  modport slave (
    input  target, start, abort, pl_req, load,
    output up, down, plN_out, pos, busy, done, LED, fsm_state
  );

  modport master (
    output target, start, abort, pl_req, load,
    input  up, down, plN_out, pos, busy, done, LED, fsm_state
  );
endinterface

// File: rtl/step_sequencer.sv
// Steps an external up/down counter from its current value to a target, one count per
// clk_slow cycle with optional idle gaps, and mirrors the counter value in pos.
module step_sequencer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0,
  parameter bit WRAP  = 1'b0
) (
  input  logic          clk_slow,
  input  logic          rstN,
  step_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    GAPW = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] HALF       = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit               HAS_GAP    = (GAP > 0);
  localparam logic [3:0]       GAP_RELOAD = HAS_GAP ? 4'(GAP - 1) : 4'd0;

  state_t           state, state_d;
  logic             up_q, up_d;
  logic             down_q, down_d;
  logic             pl_q, pl_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       gap_cnt, gap_d;

  logic [WIDTH-1:0] diff;
  logic             dir_up;
  logic [WIDTH-1:0] pos_step;

  // Direction is re-evaluated every step from the live mirror and the latched target.
  always_comb begin
    diff     = tgt_q - pos_q;
    dir_up   = WRAP ? (diff <= HALF) : (pos_q < tgt_q);
    pos_step = dir_up ? (pos_q + ONE) : (pos_q - ONE);
  end

  // State register together with all registered outputs.
  always_ff @(posedge clk_slow or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      pl_q    <= 1'b1;
      pos_q   <= '0;
      tgt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gap_cnt <= 4'd0;
    end else begin
      state   <= state_d;
      up_q    <= up_d;
      down_q  <= down_d;
      pl_q    <= pl_d;
      pos_q   <= pos_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gap_cnt <= gap_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (bus.pl_req) begin
          state_d = IDLE;
        end else if (bus.start) begin
          state_d = (bus.target == pos_q) ? DONE : STEP;
        end
      end
      STEP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (pos_step == tgt_q) begin
          state_d = DONE;
        end else if (HAS_GAP) begin
          state_d = GAPW;
        end else begin
          state_d = STEP;
        end
      end
      GAPW: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (gap_cnt == 4'd0) begin
          state_d = STEP;
        end
      end
      DONE: begin
        // First DONE cycle raises done; the second drops it and returns to IDLE.
        if (done_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    up_d   = 1'b0;
    down_d = 1'b0;
    pl_d   = 1'b1;
    pos_d  = pos_q;
    tgt_d  = tgt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    gap_d  = gap_cnt;
    case (state)
      IDLE: begin
        if (bus.pl_req) begin
          pl_d  = 1'b0;
          pos_d = bus.load;
        end else if (bus.start) begin
          tgt_d  = bus.target;
          busy_d = (bus.target != pos_q);
        end
      end
      STEP: begin
        if (bus.abort) begin
          busy_d = 1'b0;
        end else begin
          up_d   = dir_up;
          down_d = !dir_up;
          pos_d  = pos_step;
          if (HAS_GAP && (pos_step != tgt_q)) begin
            gap_d = GAP_RELOAD;
          end
        end
      end
      GAPW: begin
        if (bus.abort) begin
          busy_d = 1'b0;
        end else if (gap_cnt != 4'd0) begin
          gap_d = gap_cnt - 4'd1;
        end
      end
      DONE: begin
        if (!done_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.up        = up_q;
  assign bus.down      = down_q;
  assign bus.plN_out   = pl_q;
  assign bus.pos       = pos_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.LED       = {tgt_q, pos_q};
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: three instances cover GAP=0/1 and WRAP=0/1 on one clock.
module tb_step_sequencer;

  logic clk_slow;
  logic rstN;
  int   total;
  int   bad;
  logic [7:0] exp_q[$];

  step_sequencer_if #(.WIDTH(8)) b0 ();
  step_sequencer_if #(.WIDTH(8)) b1 ();
  step_sequencer_if #(.WIDTH(8)) b2 ();

  step_sequencer #(.WIDTH(8), .GAP(0), .WRAP(1'b0)) u0 (.clk_slow(clk_slow), .rstN(rstN), .bus(b0));
  step_sequencer #(.WIDTH(8), .GAP(1), .WRAP(1'b0)) u1 (.clk_slow(clk_slow), .rstN(rstN), .bus(b1));
  step_sequencer #(.WIDTH(8), .GAP(0), .WRAP(1'b1)) u2 (.clk_slow(clk_slow), .rstN(rstN), .bus(b2));

  // Clock and reset
  initial clk_slow = 1'b0;
  always #5 clk_slow = ~clk_slow;

  task automatic cyc();
    @(posedge clk_slow);
    @(negedge clk_slow);
  endtask

  task automatic clear_inputs();
    b0.target = 8'h00; b0.start = 1'b0; b0.abort = 1'b0; b0.pl_req = 1'b0; b0.load = 8'h00;
    b1.target = 8'h00; b1.start = 1'b0; b1.abort = 1'b0; b1.pl_req = 1'b0; b1.load = 8'h00;
    b2.target = 8'h00; b2.start = 1'b0; b2.abort = 1'b0; b2.pl_req = 1'b0; b2.load = 8'h00;
  endtask

  task automatic test_reset();
    rstN = 1'b1;
    #1 rstN = 1'b0;
    #3;
    total++; if (b0.up !== 1'b0) begin bad++; $display("FAIL reset_up got=%b want=0", b0.up); end
    total++; if (b0.down !== 1'b0) begin bad++; $display("FAIL reset_down got=%b want=0", b0.down); end
    total++; if (b0.plN_out !== 1'b1) begin bad++; $display("FAIL reset_plN got=%b want=1", b0.plN_out); end
    total++; if (b0.pos !== 8'h00) begin bad++; $display("FAIL reset_pos got=%h want=00", b0.pos); end
    total++; if (b0.busy !== 1'b0 || b0.done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b want=00", b0.busy, b0.done); end
    total++; if (b0.LED !== 16'h0000) begin bad++; $display("FAIL reset_led got=%h want=0000", b0.LED); end
    total++; if (b0.fsm_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", b0.fsm_state); end
    @(negedge clk_slow);
    rstN = 1'b1;
    cyc();
  endtask

  // Preload all three instances; the start sent alongside pl_req on b0 must be dropped.
  task automatic test_preload();
    b0.pl_req = 1'b1; b0.load = 8'h10; b0.start = 1'b1; b0.target = 8'h55;
    b1.pl_req = 1'b1; b1.load = 8'h10;
    b2.pl_req = 1'b1; b2.load = 8'hFE;
    cyc();
    clear_inputs();
    total++; if (b0.plN_out !== 1'b0) begin bad++; $display("FAIL preload_plN_low got=%b want=0", b0.plN_out); end
    total++; if (b0.pos !== 8'h10) begin bad++; $display("FAIL preload_pos got=%h want=10", b0.pos); end
    total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL preload_busy got=%b want=0", b0.busy); end
    total++; if (b2.pos !== 8'hFE) begin bad++; $display("FAIL preload_pos_b2 got=%h want=fe", b2.pos); end
    cyc();
    total++; if (b0.plN_out !== 1'b1) begin bad++; $display("FAIL preload_plN_high got=%b want=1", b0.plN_out); end
    total++; if (b0.LED !== 16'h0010) begin bad++; $display("FAIL preload_start_dropped got=%h want=0010", b0.LED); end
    total++; if (b0.fsm_state !== 2'd0 || b0.busy !== 1'b0) begin bad++; $display("FAIL preload_idle got=%0d/%b want=0/0", b0.fsm_state, b0.busy); end
  endtask

  task automatic test_step_up_gap0();
    b0.start = 1'b1; b0.target = 8'h13;
    cyc();
    clear_inputs();
    total++; if (b0.busy !== 1'b1 || b0.up !== 1'b0) begin bad++; $display("FAIL up_accept busy/up got=%b/%b want=1/0", b0.busy, b0.up); end
    for (int i = 1; i <= 3; i++) begin
      cyc();
      total++; if (b0.up !== 1'b1 || b0.down !== 1'b0) begin bad++; $display("FAIL up_step%0d up/down got=%b/%b want=1/0", i, b0.up, b0.down); end
      total++; if (b0.pos !== 8'(8'h10 + i)) begin bad++; $display("FAIL up_pos%0d got=%h want=%h", i, b0.pos, 8'(8'h10 + i)); end
    end
    cyc();
    total++; if (b0.up !== 1'b0 || b0.done !== 1'b1 || b0.busy !== 1'b0) begin bad++; $display("FAIL up_done up/done/busy got=%b/%b/%b want=0/1/0", b0.up, b0.done, b0.busy); end
    cyc();
    total++; if (b0.done !== 1'b0 || b0.fsm_state !== 2'd0) begin bad++; $display("FAIL up_idle done/state got=%b/%0d want=0/0", b0.done, b0.fsm_state); end
    total++; if (b0.LED !== 16'h1313) begin bad++; $display("FAIL up_led got=%h want=1313", b0.LED); end
  endtask

  task automatic test_step_down_gap1();
    logic [2:0] want_down;
    logic [7:0] want_pos[3];
    int done_cnt;
    want_down = 3'b101;
    want_pos[0] = 8'h0F; want_pos[1] = 8'h0F; want_pos[2] = 8'h0E;
    b1.start = 1'b1; b1.target = 8'h0E;
    cyc();
    clear_inputs();
    total++; if (b1.busy !== 1'b1) begin bad++; $display("FAIL gap_accept busy got=%b want=1", b1.busy); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (b1.down !== want_down[2-i] || b1.up !== 1'b0) begin bad++; $display("FAIL gap_down%0d down/up got=%b/%b want=%b/0", i, b1.down, b1.up, want_down[2-i]); end
      total++; if (b1.pos !== want_pos[i]) begin bad++; $display("FAIL gap_pos%0d got=%h want=%h", i, b1.pos, want_pos[i]); end
    end
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (b1.done === 1'b1) done_cnt++;
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL gap_done_pulses got=%0d want=1", done_cnt); end
    total++; if (b1.busy !== 1'b0 || b1.down !== 1'b0) begin bad++; $display("FAIL gap_end busy/down got=%b/%b want=0/0", b1.busy, b1.down); end
  endtask

  task automatic test_wrap();
    int down_cnt;
    int up_seen;
    bit seen_done;
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    b2.start = 1'b1; b2.target = 8'h02;
    cyc();
    clear_inputs();
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      cyc();
      e = exp_q.pop_front();
      total++; if (b2.up !== 1'b1 || b2.down !== 1'b0) begin bad++; $display("FAIL wrap_dir up/down got=%b/%b want=1/0", b2.up, b2.down); end
      total++; if (b2.pos !== e) begin bad++; $display("FAIL wrap_pos got=%h want=%h", b2.pos, e); end
    end
    cyc();
    total++; if (b2.done !== 1'b1 || b2.up !== 1'b0) begin bad++; $display("FAIL wrap_done done/up got=%b/%b want=1/0", b2.done, b2.up); end

    // Same stimulus on the linear instance goes the long way down.
    b0.pl_req = 1'b1; b0.load = 8'hFE;
    cyc();
    clear_inputs();
    b0.start = 1'b1; b0.target = 8'h02;
    cyc();
    clear_inputs();
    down_cnt = 0; up_seen = 0; seen_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (b0.done === 1'b1) begin
        seen_done = 1'b1;
        break;
      end
      if (b0.down === 1'b1) down_cnt++;
      if (b0.up === 1'b1) up_seen++;
    end
    total++; if (seen_done !== 1'b1) begin bad++; $display("FAIL linear_timeout done got=%b want=1", seen_done); end
    total++; if (down_cnt !== 252) begin bad++; $display("FAIL linear_down_count got=%0d want=252", down_cnt); end
    total++; if (up_seen !== 0) begin bad++; $display("FAIL linear_up_seen got=%0d want=0", up_seen); end
    total++; if (b0.pos !== 8'h02) begin bad++; $display("FAIL linear_pos got=%h want=02", b0.pos); end
    cyc();
  endtask

  task automatic test_abort_ignore();
    b0.pl_req = 1'b1; b0.load = 8'h10;
    cyc();
    clear_inputs();
    b0.start = 1'b1; b0.target = 8'h20;
    cyc();
    clear_inputs();
    b0.start = 1'b1; b0.target = 8'h05; b0.pl_req = 1'b1; b0.load = 8'h77;
    cyc();
    clear_inputs();
    total++; if (b0.up !== 1'b1 || b0.pos !== 8'h11) begin bad++; $display("FAIL busy_ignore up/pos got=%b/%h want=1/11", b0.up, b0.pos); end
    total++; if (b0.plN_out !== 1'b1) begin bad++; $display("FAIL busy_ignore_plN got=%b want=1", b0.plN_out); end
    cyc();
    total++; if (b0.up !== 1'b1 || b0.pos !== 8'h12) begin bad++; $display("FAIL abort_pre up/pos got=%b/%h want=1/12", b0.up, b0.pos); end
    b0.abort = 1'b1;
    cyc();
    clear_inputs();
    total++; if (b0.up !== 1'b0 || b0.down !== 1'b0 || b0.busy !== 1'b0) begin bad++; $display("FAIL abort_stop up/down/busy got=%b/%b/%b want=0/0/0", b0.up, b0.down, b0.busy); end
    total++; if (b0.pos !== 8'h12 || b0.fsm_state !== 2'd0) begin bad++; $display("FAIL abort_pos_state got=%h/%0d want=12/0", b0.pos, b0.fsm_state); end
    cyc();
    total++; if (b0.done !== 1'b0 || b0.LED !== 16'h2012) begin bad++; $display("FAIL abort_no_done done/led got=%b/%h want=0/2012", b0.done, b0.LED); end
  endtask

  task automatic test_equal_target();
    b0.start = 1'b1; b0.target = 8'h12;
    cyc();
    clear_inputs();
    total++; if (b0.busy !== 1'b0 || b0.done !== 1'b0 || b0.up !== 1'b0) begin bad++; $display("FAIL equal_first busy/done/up got=%b/%b/%b want=0/0/0", b0.busy, b0.done, b0.up); end
    cyc();
    total++; if (b0.done !== 1'b1 || b0.up !== 1'b0 || b0.down !== 1'b0) begin bad++; $display("FAIL equal_done done/up/down got=%b/%b/%b want=1/0/0", b0.done, b0.up, b0.down); end
    cyc();
    total++; if (b0.done !== 1'b0 || b0.pos !== 8'h12) begin bad++; $display("FAIL equal_end done/pos got=%b/%h want=0/12", b0.done, b0.pos); end
  endtask

  task automatic test_reset_mid();
    b0.start = 1'b1; b0.target = 8'h30;
    cyc();
    clear_inputs();
    cyc();
    cyc();
    total++; if (b0.up !== 1'b1 || b0.pos !== 8'h14) begin bad++; $display("FAIL mid_pre up/pos got=%b/%h want=1/14", b0.up, b0.pos); end
    #2 rstN = 1'b0;
    #1;
    total++; if (b0.up !== 1'b0 || b0.down !== 1'b0 || b0.busy !== 1'b0) begin bad++; $display("FAIL mid_reset up/down/busy got=%b/%b/%b want=0/0/0", b0.up, b0.down, b0.busy); end
    total++; if (b0.pos !== 8'h00 || b0.LED !== 16'h0000) begin bad++; $display("FAIL mid_reset pos/led got=%h/%h want=00/0000", b0.pos, b0.LED); end
    @(negedge clk_slow);
    rstN = 1'b1;
    cyc();
    total++; if (b0.up !== 1'b0 || b0.pos !== 8'h00 || b0.fsm_state !== 2'd0) begin bad++; $display("FAIL mid_after up/pos/state got=%b/%h/%0d want=0/00/0", b0.up, b0.pos, b0.fsm_state); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    clear_inputs();
    test_reset();
    test_preload();
    test_step_up_gap0();
    test_step_down_gap1();
    test_wrap();
    test_abort_ignore();
    test_equal_target();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
